// File: rtl/mc_control_unit_pkg.sv
// ---------------------------------------------------------------------------
// mc_control_unit_pkg
// Shared types for the multi-cycle RV32I control unit: FSM state encodings,
// instruction class codes (also the aluop values), RV32I opcode constants and
// the opcode decoder used in the DECODE state.
// ---------------------------------------------------------------------------
package mc_control_unit_pkg;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        NOP    = 3'd0,
        R_TYPE = 3'd1,
        I_TYPE = 3'd2,
        LOAD   = 3'd3,
        STORE  = 3'd4,
        BRANCH = 3'd5,
        JUMP   = 3'd6,
        U_TYPE = 3'd7
    } cls_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    // Everything the unit needs to remember about the instruction after DECODE.
    typedef struct packed {
        cls_t cls;
        logic is_jalr;
        logic is_lui;
    } decode_t;

    // Unsupported opcodes decode to class NOP; no legal opcode maps there,
    // so NOP doubles as the "illegal" marker.
    function automatic decode_t decode_op(input logic [6:0] op);
        decode_t d;
        d.cls     = NOP;
        d.is_jalr = 1'b0;
        d.is_lui  = 1'b0;
        case (op)
            OP_R:      d.cls = R_TYPE;
            OP_I:      d.cls = I_TYPE;
            OP_LOAD:   d.cls = LOAD;
            OP_STORE:  d.cls = STORE;
            OP_BRANCH: d.cls = BRANCH;
            OP_JAL:    d.cls = JUMP;
            OP_JALR: begin
                d.cls     = JUMP;
                d.is_jalr = 1'b1;
            end
            OP_LUI: begin
                d.cls    = U_TYPE;
                d.is_lui = 1'b1;
            end
            OP_AUIPC:  d.cls = U_TYPE;
            default:   d.cls = NOP;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/mc_control_unit_if.sv
// ---------------------------------------------------------------------------
// mc_control_unit_if
// Memory request handshake between the control unit and the memory.
//   mem_req   : access request (control unit -> memory)
//   memwrite  : the access is a write (control unit -> memory)
//   mem_ready : access complete this cycle (memory -> control unit)
// ---------------------------------------------------------------------------
interface mc_control_unit_if;
    logic mem_req;
    logic memwrite;
    logic mem_ready;

    modport master (output mem_req, output memwrite, input mem_ready);
    modport slave  (input mem_req, input memwrite, output mem_ready);
endinterface

// File: rtl/mc_wait_ctr.sv
// ---------------------------------------------------------------------------
// mc_wait_ctr
// Memory wait timer. With MEM_LATENCY=0, done is mem_ready passed through.
// With MEM_LATENCY=N>0, a counter advances while en is high and done rises
// when it reaches N-1, so an access lasts exactly N cycles.
//   clk, rst  : clock, synchronous active-high reset
//   clr       : clear the counter (access finished)
//   en        : an access is in progress
//   mem_ready : memory handshake, used only when MEM_LATENCY=0
//   done      : access complete this cycle (caller qualifies with en)
// ---------------------------------------------------------------------------
module mc_wait_ctr #(
    parameter int MEM_LATENCY = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    input  logic mem_ready,
    output logic done
);

    localparam int CTR_W = (MEM_LATENCY < 1) ? 1 : $clog2(MEM_LATENCY + 1);

    generate
        if (MEM_LATENCY == 0) begin : g_ready
            logic unused_ctl;
            assign unused_ctl = &{1'b0, clk, rst, clr, en};
            assign done       = mem_ready;
        end else begin : g_count
            logic [CTR_W-1:0] cnt_q;
            logic             unused_rdy;

            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples pre-edge values regardless of block ordering.
            // Cleared on every access exit, so it never counts past N-1.
            always_ff @(posedge clk) begin
                if (rst || clr) begin
                    cnt_q <= '0;
                end else if (en) begin
                    cnt_q <= cnt_q + CTR_W'(1);
                end
            end

            assign done       = (cnt_q == CTR_W'(MEM_LATENCY - 1));
            assign unused_rdy = mem_ready;
        end
    endgenerate

endmodule

// File: rtl/mc_control_unit.sv
// ---------------------------------------------------------------------------
// mc_control_unit
// Multi-cycle RV32I control unit. Sequences each instruction through
// FETCH/DECODE/EXEC/MEM/WB, stalling on memory, and traps on unsupported
// opcodes until reset.
//   clk, rst     : clock, synchronous active-high reset
//   mem          : memory handshake (mem_req, memwrite out; mem_ready in)
//   opcode       : ir[6:0], sampled in DECODE
//   branch_taken : branch comparison, used in EXEC
//   pc_write, ir_write, regwrite, memtoreg, alusrc1, alusrc2, lui, pcsrc,
//   jump, branch : datapath enables/selects
//   aluop        : instruction class code
//   state        : current FSM state (debug)
//   illegal      : sticky unsupported-opcode flag
// ---------------------------------------------------------------------------
module mc_control_unit
    import mc_control_unit_pkg::*;
#(
    parameter int MEM_LATENCY = 0,
    parameter int ALUOP_W     = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    mc_control_unit_if.master      mem,
    input  logic [6:0]             opcode,
    input  logic                   branch_taken,
    output logic                   pc_write,
    output logic                   ir_write,
    output logic                   regwrite,
    output logic                   memtoreg,
    output logic                   alusrc1,
    output logic                   alusrc2,
    output logic                   lui,
    output logic                   pcsrc,
    output logic                   jump,
    output logic                   branch,
    output logic [ALUOP_W-1:0]     aluop,
    output logic [2:0]             state,
    output logic                   illegal
);

    state_t  st_q;
    decode_t dec_q;
    decode_t dec_d;
    logic    illegal_q;
    logic    in_access;
    logic    done;
    logic    access_done;

    assign dec_d       = decode_op(opcode);
    assign in_access   = !rst && (st_q == S_FETCH || st_q == S_MEM);
    assign access_done = in_access && done;

    mc_wait_ctr #(.MEM_LATENCY(MEM_LATENCY)) u_wait_ctr (
        .clk       (clk),
        .rst       (rst),
        .clr       (access_done),
        .en        (in_access),
        .mem_ready (mem.mem_ready),
        .done      (done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q      <= S_FETCH;
            dec_q     <= '{cls: NOP, is_jalr: 1'b0, is_lui: 1'b0};
            illegal_q <= 1'b0;
        end else begin
            case (st_q)
                S_FETCH: if (access_done) st_q <= S_DECODE;
                S_DECODE: begin
                    dec_q <= dec_d;
                    if (dec_d.cls != NOP) begin
                        st_q <= S_EXEC;
                    end else begin
                        st_q      <= S_TRAP;
                        illegal_q <= 1'b1;
                    end
                end
                S_EXEC: begin
                    case (dec_q.cls)
                        LOAD, STORE: st_q <= S_MEM;
                        BRANCH:      st_q <= S_FETCH;
                        default:     st_q <= S_WB;
                    endcase
                end
                S_MEM: if (access_done) st_q <= (dec_q.cls == LOAD) ? S_WB : S_FETCH;
                S_WB:   st_q <= S_FETCH;
                S_TRAP: st_q <= S_TRAP;
                default: st_q <= S_FETCH;
            endcase
        end
    end

    // Outputs decode registered state and class; branch_taken and the
    // access-complete signal feed through because the pulses must land in
    // the same cycle. Reset forces every output low.
    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        pc_write     = 1'b0;
        ir_write     = 1'b0;
        regwrite     = 1'b0;
        memtoreg     = 1'b0;
        alusrc1      = 1'b0;
        alusrc2      = 1'b0;
        lui          = 1'b0;
        pcsrc        = 1'b0;
        jump         = 1'b0;
        branch       = 1'b0;
        aluop        = '0;
        state        = S_FETCH;
        illegal      = 1'b0;
        mem.mem_req  = 1'b0;
        mem.memwrite = 1'b0;
        if (!rst) begin
            state   = st_q;
            illegal = illegal_q;
            // Class-static selects live from EXEC until the instruction ends.
            if (st_q == S_EXEC || st_q == S_MEM || st_q == S_WB) begin
                aluop    = ALUOP_W'(dec_q.cls);
                alusrc2  = dec_q.cls inside {I_TYPE, LOAD, STORE, U_TYPE};
                alusrc1  = (dec_q.cls == JUMP);
                memtoreg = (dec_q.cls == LOAD);
                lui      = dec_q.is_lui;
                pcsrc    = dec_q.is_jalr;
            end
            case (st_q)
                S_FETCH: begin
                    mem.mem_req = 1'b1;
                    ir_write    = access_done;
                    pc_write    = access_done;
                end
                S_EXEC: begin
                    if (dec_q.cls == BRANCH) begin
                        branch   = 1'b1;
                        pc_write = branch_taken;
                    end
                end
                S_MEM: begin
                    mem.mem_req  = 1'b1;
                    mem.memwrite = (dec_q.cls == STORE);
                end
                S_WB: begin
                    regwrite = 1'b1;
                    if (dec_q.cls == JUMP) begin
                        jump     = 1'b1;
                        pc_write = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mc_control_unit.sv
// ---------------------------------------------------------------------------
// tb_mc_control_unit
// Two instances share the stimulus: u_dut0 (MEM_LATENCY=0) and u_dut3
// (MEM_LATENCY=3). The driver sets inputs one cycle at a time and queues the
// hand-computed output vector expected for that cycle; a monitor per DUT
// pops and compares on the falling edge.
// Vector layout: {pc_write, ir_write, mem_req, memwrite, regwrite, memtoreg,
//                 alusrc1, alusrc2, lui, pcsrc, jump, branch,
//                 aluop[2:0], state[2:0], illegal}
// ---------------------------------------------------------------------------
module tb_mc_control_unit;
    import mc_control_unit_pkg::*;

    localparam logic [11:0] E_PCW = 12'h800;
    localparam logic [11:0] E_IRW = 12'h400;
    localparam logic [11:0] E_REQ = 12'h200;
    localparam logic [11:0] E_MW  = 12'h100;
    localparam logic [11:0] E_RW  = 12'h080;
    localparam logic [11:0] E_M2R = 12'h040;
    localparam logic [11:0] E_AS1 = 12'h020;
    localparam logic [11:0] E_AS2 = 12'h010;
    localparam logic [11:0] E_LUI = 12'h008;
    localparam logic [11:0] E_PCS = 12'h004;
    localparam logic [11:0] E_JMP = 12'h002;
    localparam logic [11:0] E_BR  = 12'h001;
    localparam logic [11:0] F_OK  = E_REQ | E_IRW | E_PCW;
    localparam logic [11:0] NONE  = 12'h000;

    typedef struct {
        logic [18:0] exp;
        string       nm;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] opcode;
    logic       mem_ready;
    logic       branch_taken;

    wire [11:0] en0, en3;
    wire [2:0]  aluop0, aluop3, state0, state3;
    wire        ill0, ill3;

    exp_t q0[$];
    exp_t q3[$];
    int   n_pass  = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    mc_control_unit_if mif0 ();
    mc_control_unit_if mif3 ();
    assign mif0.mem_ready = mem_ready;
    assign mif3.mem_ready = mem_ready;
    assign en0[9] = mif0.mem_req;
    assign en0[8] = mif0.memwrite;
    assign en3[9] = mif3.mem_req;
    assign en3[8] = mif3.memwrite;

    mc_control_unit #(.MEM_LATENCY(0), .ALUOP_W(3)) u_dut0 (
        .clk(clk), .rst(rst), .mem(mif0.master), .opcode(opcode), .branch_taken(branch_taken),
        .pc_write(en0[11]), .ir_write(en0[10]), .regwrite(en0[7]), .memtoreg(en0[6]),
        .alusrc1(en0[5]), .alusrc2(en0[4]), .lui(en0[3]), .pcsrc(en0[2]), .jump(en0[1]),
        .branch(en0[0]), .aluop(aluop0), .state(state0), .illegal(ill0)
    );

    mc_control_unit #(.MEM_LATENCY(3), .ALUOP_W(3)) u_dut3 (
        .clk(clk), .rst(rst), .mem(mif3.master), .opcode(opcode), .branch_taken(branch_taken),
        .pc_write(en3[11]), .ir_write(en3[10]), .regwrite(en3[7]), .memtoreg(en3[6]),
        .alusrc1(en3[5]), .alusrc2(en3[4]), .lui(en3[3]), .pcsrc(en3[2]), .jump(en3[1]),
        .branch(en3[0]), .aluop(aluop3), .state(state3), .illegal(ill3)
    );

    function automatic logic [18:0] mk(input logic [2:0] st, input logic [2:0] c,
                                       input logic [11:0] en, input logic ill);
        return {en, c, st, ill};
    endfunction

    task automatic check(input string nm, input logic [18:0] act, input logic [18:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got en=%h aluop=%0d state=%0d illegal=%b, required en=%h aluop=%0d state=%0d illegal=%b",
                     nm, act[18:7], act[6:4], act[3:1], act[0], exp[18:7], exp[6:4], exp[3:1], exp[0]);
        else
            n_pass++;
    endtask

    // One cycle of stimulus plus the output vector expected during it.
    task automatic step(input int d, input logic r, input logic [6:0] op, input logic mr,
                        input logic bt, input logic [18:0] e, input string nm);
        exp_t x;
        rst          = r;
        opcode       = op;
        mem_ready    = mr;
        branch_taken = bt;
        x.exp = e;
        x.nm  = nm;
        if (d == 0) q0.push_back(x);
        else        q3.push_back(x);
        @(posedge clk);
        #1;
    endtask

    task automatic rst_step(input int d, input string nm);
        step(d, 1'b1, OP_R, 1'b0, 1'b0, mk(S_FETCH, NOP, NONE, 1'b0), nm);
    endtask

    // Fetch-decode-exec-wb for a single-cycle-class instruction on u_dut0.
    task automatic alu_instr(input logic [6:0] op, input logic [2:0] c,
                             input logic [11:0] sel, input logic [11:0] wb_extra, input string nm);
        step(0, 1'b0, op, 1'b1, 1'b0, mk(S_FETCH, NOP, F_OK, 1'b0), {nm, "_fetch"});
        step(0, 1'b0, op, 1'b1, 1'b0, mk(S_DECODE, NOP, NONE, 1'b0), {nm, "_decode"});
        step(0, 1'b0, op, 1'b1, 1'b0, mk(S_EXEC, c, sel, 1'b0), {nm, "_exec"});
        step(0, 1'b0, op, 1'b1, 1'b0, mk(S_WB, c, sel | E_RW | wb_extra, 1'b0), {nm, "_wb"});
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q0.size() != 0) begin
            e = q0.pop_front();
            check({"dut0 ", e.nm}, {en0, aluop0, state0, ill0}, e.exp);
        end
        if (q3.size() != 0) begin
            e = q3.pop_front();
            check({"dut3 ", e.nm}, {en3, aluop3, state3, ill3}, e.exp);
        end
    end

    initial begin
        rst          = 1'b1;
        opcode       = OP_R;
        mem_ready    = 1'b0;
        branch_taken = 1'b0;
        @(posedge clk);
        #1;

        // Reset held, then R/I/LUI/AUIPC/JAL at zero wait.
        for (int i = 0; i < 3; i++) rst_step(0, "reset_held");
        alu_instr(OP_R,     R_TYPE, NONE,          NONE,          "rtype");
        alu_instr(OP_I,     I_TYPE, E_AS2,         NONE,          "itype");
        alu_instr(OP_LUI,   U_TYPE, E_AS2 | E_LUI, NONE,          "lui");
        alu_instr(OP_AUIPC, U_TYPE, E_AS2,         NONE,          "auipc");
        alu_instr(OP_JAL,   JUMP,   E_AS1,         E_JMP | E_PCW, "jal");
        step(0, 1'b0, OP_R, 1'b0, 1'b0, mk(S_FETCH, NOP, E_REQ, 1'b0), "fetch_wait");

        // LOAD with a fixed 3-cycle memory; mem_ready high must be ignored.
        rst_step(3, "load3_reset");
        step(3, 1'b0, OP_LOAD, 1'b1, 1'b0, mk(S_FETCH, NOP, E_REQ, 1'b0), "load3_fetch0");
        step(3, 1'b0, OP_LOAD, 1'b1, 1'b0, mk(S_FETCH, NOP, E_REQ, 1'b0), "load3_fetch1");
        step(3, 1'b0, OP_LOAD, 1'b1, 1'b0, mk(S_FETCH, NOP, F_OK, 1'b0), "load3_fetch2");
        step(3, 1'b0, OP_LOAD, 1'b1, 1'b0, mk(S_DECODE, NOP, NONE, 1'b0), "load3_decode");
        step(3, 1'b0, OP_LOAD, 1'b1, 1'b0, mk(S_EXEC, LOAD, E_AS2 | E_M2R, 1'b0), "load3_exec");
        for (int i = 0; i < 3; i++)
            step(3, 1'b0, OP_LOAD, 1'b1, 1'b0, mk(S_MEM, LOAD, E_REQ | E_AS2 | E_M2R, 1'b0), "load3_mem");
        step(3, 1'b0, OP_LOAD, 1'b1, 1'b0, mk(S_WB, LOAD, E_RW | E_AS2 | E_M2R, 1'b0), "load3_wb");
        step(3, 1'b0, OP_LOAD, 1'b0, 1'b0, mk(S_FETCH, NOP, E_REQ, 1'b0), "load3_refetch");

        // Branch taken then not taken.
        rst_step(0, "br_reset");
        step(0, 1'b0, OP_BRANCH, 1'b1, 1'b0, mk(S_FETCH, NOP, F_OK, 1'b0), "brt_fetch");
        step(0, 1'b0, OP_BRANCH, 1'b1, 1'b0, mk(S_DECODE, NOP, NONE, 1'b0), "brt_decode");
        step(0, 1'b0, OP_BRANCH, 1'b1, 1'b1, mk(S_EXEC, BRANCH, E_BR | E_PCW, 1'b0), "brt_exec");
        step(0, 1'b0, OP_BRANCH, 1'b1, 1'b0, mk(S_FETCH, NOP, F_OK, 1'b0), "brn_fetch");
        step(0, 1'b0, OP_BRANCH, 1'b1, 1'b0, mk(S_DECODE, NOP, NONE, 1'b0), "brn_decode");
        step(0, 1'b0, OP_BRANCH, 1'b1, 1'b0, mk(S_EXEC, BRANCH, E_BR, 1'b0), "brn_exec");
        step(0, 1'b0, OP_R,      1'b1, 1'b0, mk(S_FETCH, NOP, F_OK, 1'b0), "brn_refetch");

        // JALR, then STORE with mem_ready withheld 5 cycles.
        rst_step(0, "jalr_reset");
        alu_instr(OP_JALR, JUMP, E_AS1 | E_PCS, E_JMP | E_PCW, "jalr");
        step(0, 1'b0, OP_STORE, 1'b1, 1'b0, mk(S_FETCH, NOP, F_OK, 1'b0), "st_fetch");
        step(0, 1'b0, OP_STORE, 1'b1, 1'b0, mk(S_DECODE, NOP, NONE, 1'b0), "st_decode");
        step(0, 1'b0, OP_STORE, 1'b0, 1'b0, mk(S_EXEC, STORE, E_AS2, 1'b0), "st_exec");
        for (int i = 0; i < 5; i++)
            step(0, 1'b0, OP_STORE, 1'b0, 1'b0, mk(S_MEM, STORE, E_REQ | E_MW | E_AS2, 1'b0), "st_mem_wait");
        step(0, 1'b0, OP_STORE, 1'b1, 1'b0, mk(S_MEM, STORE, E_REQ | E_MW | E_AS2, 1'b0), "st_mem_done");
        step(0, 1'b0, OP_STORE, 1'b0, 1'b0, mk(S_FETCH, NOP, E_REQ, 1'b0), "st_refetch");

        // Illegal opcode traps until reset; noise on inputs must not escape.
        rst_step(0, "trap_reset");
        step(0, 1'b0, 7'b1111111, 1'b1, 1'b0, mk(S_FETCH, NOP, F_OK, 1'b0), "trap_fetch");
        step(0, 1'b0, 7'b1111111, 1'b1, 1'b0, mk(S_DECODE, NOP, NONE, 1'b0), "trap_decode");
        for (int i = 0; i < 11; i++)
            step(0, 1'b0, 7'b1111111, 1'b1, 1'b1, mk(S_TRAP, NOP, NONE, 1'b1), "trap_hold");
        rst_step(0, "trap_clear");
        step(0, 1'b0, OP_R, 1'b0, 1'b0, mk(S_FETCH, NOP, E_REQ, 1'b0), "trap_after");

        // Reset mid-MEM on the fixed-latency unit abandons the access.
        rst_step(3, "midmem_reset");
        step(3, 1'b0, OP_STORE, 1'b0, 1'b0, mk(S_FETCH, NOP, E_REQ, 1'b0), "midmem_fetch0");
        step(3, 1'b0, OP_STORE, 1'b0, 1'b0, mk(S_FETCH, NOP, E_REQ, 1'b0), "midmem_fetch1");
        step(3, 1'b0, OP_STORE, 1'b0, 1'b0, mk(S_FETCH, NOP, F_OK, 1'b0), "midmem_fetch2");
        step(3, 1'b0, OP_STORE, 1'b0, 1'b0, mk(S_DECODE, NOP, NONE, 1'b0), "midmem_decode");
        step(3, 1'b0, OP_STORE, 1'b0, 1'b0, mk(S_EXEC, STORE, E_AS2, 1'b0), "midmem_exec");
        step(3, 1'b0, OP_STORE, 1'b0, 1'b0, mk(S_MEM, STORE, E_REQ | E_MW | E_AS2, 1'b0), "midmem_mem");
        rst_step(3, "midmem_rst");
        step(3, 1'b0, OP_STORE, 1'b0, 1'b0, mk(S_FETCH, NOP, E_REQ, 1'b0), "midmem_ref0");
        step(3, 1'b0, OP_STORE, 1'b0, 1'b0, mk(S_FETCH, NOP, E_REQ, 1'b0), "midmem_ref1");
        step(3, 1'b0, OP_STORE, 1'b0, 1'b0, mk(S_FETCH, NOP, F_OK, 1'b0), "midmem_ref2");

        repeat (3) @(posedge clk);
        if (q0.size() != 0 || q3.size() != 0) begin
            n_total++;
            $display("FAIL drain: %0d/%0d entries left, required 0/0", q0.size(), q3.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
